// File: rtl/pipe_divider.sv
// pipe_divider: fully pipelined restoring divider, one quotient bit per stage.
// Throughput one operation per cycle; a stalled output freezes the whole pipe.
// Latency from acceptance edge to out_valid is DIVIDEND_W cycles. When
// PIPE_DIVIDER_SIGNED_EN is defined, operands are two's complement and one
// sign-correction stage is added, giving a latency of DIVIDEND_W+1.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   in_valid/in_ready              operand handshake (in_ready = !stall)
//   dividend, divisor, in_tag      operands and caller tag
//   out_valid/out_ready            result handshake
//   quotient, remainder            result
//   div_by_zero, out_tag           divisor-was-zero flag, tag of this result
module pipe_divider #(
    parameter int unsigned DIVIDEND_W = 26,
    parameter int unsigned DIVISOR_W  = 14,
    parameter int unsigned TAG_W      = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic [TAG_W-1:0]      out_tag
);

    localparam int unsigned NSTG = DIVIDEND_W;

    // dq holds unconsumed dividend bits at the top and resolved quotient bits at the bottom
    typedef struct packed {
        logic                  vld;
        logic [DIVIDEND_W-1:0] dq;
        logic [DIVISOR_W-1:0]  rem;
        logic [DIVISOR_W-1:0]  dvs;
        logic [TAG_W-1:0]      tag;
        logic                  dz;
`ifdef PIPE_DIVIDER_SIGNED_EN
        logic                  qneg;
        logic                  rneg;
`endif
    } stage_t;

    stage_t st_q [NSTG];
    stage_t st_d [NSTG];
    stage_t head_c;
    stage_t tail_c;
    logic   stall_c;

    logic                  out_valid_q;
    logic [DIVIDEND_W-1:0] quotient_q;
    logic [DIVISOR_W-1:0]  remainder_q;
    logic                  div_by_zero_q;
    logic [TAG_W-1:0]      out_tag_q;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    function automatic stage_t step(input stage_t s);
        stage_t             r;
        logic [DIVISOR_W:0] partial;
        logic [DIVISOR_W:0] diff;
        r       = s;
        partial = {s.rem, s.dq[DIVIDEND_W-1]};
        diff    = partial - {1'b0, s.dvs};
        if (partial >= {1'b0, s.dvs}) begin
            r.rem = diff[DIVISOR_W-1:0];
            r.dq  = {s.dq[DIVIDEND_W-2:0], 1'b1};
        end else begin
            r.rem = partial[DIVISOR_W-1:0];
            r.dq  = {s.dq[DIVIDEND_W-2:0], 1'b0};
        end
        return r;
    endfunction

    assign stall_c  = out_valid_q && !out_ready;
    assign in_ready = !stall_c;

    // Operand conditioning; a zero divisor runs the raw dividend so the
    // array naturally yields all-ones quotient and dividend low bits as remainder
    always_comb begin
        head_c     = '0;
        head_c.vld = in_valid;
        head_c.tag = in_tag;
        head_c.dz  = (divisor == '0);
        head_c.dq  = dividend;
        head_c.dvs = divisor;
`ifdef PIPE_DIVIDER_SIGNED_EN
        if (!head_c.dz) begin
            if (dividend[DIVIDEND_W-1]) head_c.dq  = -dividend;
            if (divisor[DIVISOR_W-1])   head_c.dvs = -divisor;
            head_c.qneg = dividend[DIVIDEND_W-1] ^ divisor[DIVISOR_W-1];
            head_c.rneg = dividend[DIVIDEND_W-1];
        end
`endif
    end

    // Next contents of every divide stage
    always_comb begin
        st_d[0] = step(head_c);
        for (int i = 1; i < NSTG; i++) begin
            st_d[i] = step(st_q[i-1]);
        end
    end

    // Divide stages; the whole pipe holds while the output is stalled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSTG; i++) begin
                st_q[i] <= '0;
            end
        end else if (!stall_c) begin
            for (int i = 0; i < NSTG; i++) begin
                st_q[i] <= st_d[i];
            end
        end
    end

`ifdef PIPE_DIVIDER_SIGNED_EN
    stage_t fix_d;
    stage_t fix_q;

    // Sign correction: quotient truncates toward zero, remainder follows dividend
    always_comb begin
        fix_d = st_q[NSTG-1];
        if (st_q[NSTG-1].qneg) fix_d.dq  = -st_q[NSTG-1].dq;
        if (st_q[NSTG-1].rneg) fix_d.rem = -st_q[NSTG-1].rem;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fix_q <= '0;
        end else if (!stall_c) begin
            fix_q <= fix_d;
        end
    end

    assign tail_c = fix_q;
`else
    assign tail_c = st_q[NSTG-1];
`endif

    // Registered result presentation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            out_tag_q     <= '0;
        end else if (!stall_c) begin
            out_valid_q   <= tail_c.vld;
            quotient_q    <= tail_c.dq;
            remainder_q   <= tail_c.rem;
            div_by_zero_q <= tail_c.dz;
            out_tag_q     <= tail_c.tag;
        end
    end

    assign out_valid   = out_valid_q;
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = div_by_zero_q;
    assign out_tag     = out_tag_q;

endmodule
